// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the pipeline and the iterative multiply/divide unit.
// The pipeline drives the master side; the sequencer is the slave.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             WeHi;
  logic             WeLo;
  logic [WIDTH-1:0] WData;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, SrcA, SrcB, WeHi, WeLo, WData,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, Op, SrcA, SrcB, WeHi, WeLo, WData,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: radix-2 shift/add multiply and
// restoring divide on magnitudes, with a one-cycle sign fix-up before HI/LO commit.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             is_div_reg, neg_res_reg, neg_rem_reg, done_reg;
  logic [WIDTH-1:0] opb_reg, a_raw_reg, wk_hi_reg, wk_lo_reg, hi_reg, lo_reg;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, div_sh, div_dif;
  logic [WIDTH-1:0] step_hi, step_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod_neg;

  // Magnitudes are taken only for the signed ops (Op[0] set).
  assign a_neg = bus.Op[0] & bus.SrcA[WIDTH-1];
  assign b_neg = bus.Op[0] & bus.SrcB[WIDTH-1];
  assign abs_a = a_neg ? -bus.SrcA : bus.SrcA;
  assign abs_b = b_neg ? -bus.SrcB : bus.SrcB;

  assign bus.Busy = (state_reg != IDLE);
  assign bus.Done = done_reg;
  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.Start) state_next = RUN;
      RUN:     if (cnt_reg == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Remainder stays below the divisor, so bit WIDTH of the difference is a clean borrow flag.
  always_comb begin
    mul_sum = {1'b0, wk_hi_reg} + (wk_lo_reg[0] ? {1'b0, opb_reg} : '0);
    div_sh  = {wk_hi_reg, wk_lo_reg[WIDTH-1]};
    div_dif = div_sh - {1'b0, opb_reg};
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], wk_lo_reg[WIDTH-1:1]};
    if (is_div_reg) begin
      step_hi = div_dif[WIDTH] ? div_sh[WIDTH-1:0] : div_dif[WIDTH-1:0];
      step_lo = {wk_lo_reg[WIDTH-2:0], ~div_dif[WIDTH]};
    end
  end

  always_comb begin
    prod_neg = -{wk_hi_reg, wk_lo_reg};
    fix_hi   = wk_hi_reg;
    fix_lo   = wk_lo_reg;
    if (!is_div_reg) begin
      if (neg_res_reg) begin
        fix_hi = prod_neg[2*WIDTH-1:WIDTH];
        fix_lo = prod_neg[WIDTH-1:0];
      end
    end else if (opb_reg == '0) begin
      fix_hi = a_raw_reg;
      fix_lo = '1;
    end else begin
      if (neg_res_reg) fix_lo = -wk_lo_reg;
      if (neg_rem_reg) fix_hi = -wk_hi_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      is_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      done_reg    <= 1'b0;
      opb_reg     <= '0;
      a_raw_reg   <= '0;
      wk_hi_reg   <= '0;
      wk_lo_reg   <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == FIX);
      case (state_reg)
        IDLE: begin
          if (bus.Start) begin
            cnt_reg     <= CNT_W'(WIDTH - 1);
            is_div_reg  <= bus.Op[1];
            neg_res_reg <= a_neg ^ b_neg;
            neg_rem_reg <= a_neg;
            a_raw_reg   <= bus.SrcA;
            wk_hi_reg   <= '0;
            opb_reg     <= bus.Op[1] ? abs_b : abs_a;
            wk_lo_reg   <= bus.Op[1] ? abs_a : abs_b;
          end else begin
            if (bus.WeHi) hi_reg <= bus.WData;
            if (bus.WeLo) lo_reg <= bus.WData;
          end
        end
        RUN: begin
          cnt_reg   <= cnt_reg - 1'b1;
          wk_hi_reg <= step_hi;
          wk_lo_reg <= step_lo;
        end
        FIX: begin
          hi_reg <= fix_hi;
          lo_reg <= fix_lo;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed plus randomized checks of muldiv_seq against a 64-bit arithmetic reference.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  muldiv_seq_if #(.WIDTH(32)) bus();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0;
    lo = '0;
    case (op)
      2'd0: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (op == 2'd2) begin
          lo = a / b;
          hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'd0;
        end else begin
          q = sa / sb;
          r = sa % sb;
          lo = 32'(q);
          hi = 32'(r);
        end
      end
    endcase
  endfunction

  // poke: busy cycle (1..33) in which a stray Start/MTHI/MTLO is driven; 0 = none.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke, input bit we_with_start);
    logic [31:0] eh, el;
    int n;
    ref_model(op, a, b, eh, el);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.SrcA = a; bus.SrcB = b;
    if (we_with_start) begin
      bus.WeHi = 1'b1; bus.WeLo = 1'b1; bus.WData = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    bus.Start = 1'b0; bus.WeHi = 1'b0; bus.WeLo = 1'b0;
    n = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      n++;
      if (n == 5) begin
        chk("hold_hi", {32'd0, bus.HI}, {32'd0, cur_hi});
        chk("hold_lo", {32'd0, bus.LO}, {32'd0, cur_lo});
        chk("done_busy", {63'd0, bus.Done}, 64'd0);
      end
      if (n == poke) begin
        bus.Start = 1'b1; bus.Op = 2'($urandom_range(3, 0));
        bus.SrcA = $urandom; bus.SrcB = $urandom;
        bus.WeHi = 1'b1; bus.WeLo = 1'b1; bus.WData = 32'h0000_0001;
      end
      @(negedge clk);
      bus.Start = 1'b0; bus.WeHi = 1'b0; bus.WeLo = 1'b0;
    end
    chk("busy_cycles", 64'(n), 64'd33);
    chk("done_pulse", {63'd0, bus.Done}, 64'd1);
    chk("hi", {32'd0, bus.HI}, {32'd0, eh});
    chk("lo", {32'd0, bus.LO}, {32'd0, el});
    $display("op=%0d a=%h b=%h poke=%0d hi=%h lo=%h exp_hi=%h exp_lo=%h",
             op, a, b, poke, bus.HI, bus.LO, eh, el);
    cur_hi = eh;
    cur_lo = el;
    @(negedge clk);
    chk("done_clear", {63'd0, bus.Done}, 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bus.Start = 1'b0; bus.Op = 2'd0; bus.SrcA = '0; bus.SrcB = '0;
    bus.WeHi = 1'b0; bus.WeLo = 1'b0; bus.WData = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, bus.Busy}, 64'd0);
    chk("rst_done", {63'd0, bus.Done}, 64'd0);
    chk("rst_hi", {32'd0, bus.HI}, 64'd0);
    chk("rst_lo", {32'd0, bus.LO}, 64'd0);
    rst_n = 1'b1;

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFD, 32'h0000_0007, 0, 1'b0);
    run_op(2'd2, 32'd100, 32'd7, 0, 1'b0);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(2'd2, 32'h0000_1234, 32'd0, 0, 1'b0);
    run_op(2'd3, 32'hFFFF_FFF0, 32'd0, 0, 1'b0);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);

    // MTLO alone, then MTHI+MTLO together.
    @(negedge clk);
    bus.WeLo = 1'b1; bus.WData = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.WeLo = 1'b0;
    chk("mtlo_lo", {32'd0, bus.LO}, 64'h0000_0000_A5A5_A5A5);
    chk("mtlo_hi", {32'd0, bus.HI}, {32'd0, cur_hi});
    $display("mtlo data=a5a5a5a5 hi=%h lo=%h", bus.HI, bus.LO);
    cur_lo = 32'hA5A5_A5A5;
    bus.WeHi = 1'b1; bus.WeLo = 1'b1; bus.WData = 32'h1357_9BDF;
    @(negedge clk);
    bus.WeHi = 1'b0; bus.WeLo = 1'b0;
    chk("mthilo_hi", {32'd0, bus.HI}, 64'h0000_0000_1357_9BDF);
    chk("mthilo_lo", {32'd0, bus.LO}, 64'h0000_0000_1357_9BDF);
    $display("mthi+mtlo data=13579bdf hi=%h lo=%h", bus.HI, bus.LO);
    cur_hi = 32'h1357_9BDF;
    cur_lo = 32'h1357_9BDF;

    // Stray Start/MTHI during RUN and in FIX; Start together with We* in IDLE.
    run_op(2'd1, 32'h0001_2345, 32'hFFFF_0F0F, 3, 1'b0);
    run_op(2'd0, 32'hCAFE_F00D, 32'h0BAD_BEEF, 33, 1'b0);
    run_op(2'd2, 32'h0FED_CBA9, 32'h0000_0123, 0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(3, 0));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(7, 0) == 0) rb = 32'd0;
      if ($urandom_range(7, 0) == 0) ra = 32'h8000_0000;
      if ($urandom_range(3, 0) == 0) rb = rb >> $urandom_range(31, 8);
      run_op(rop, ra, rb, 0, 1'b0);
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = 2'd2; bus.SrcA = 32'd1000; bus.SrcB = 32'd3;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, bus.Busy}, 64'd0);
    chk("midrst_hi", {32'd0, bus.HI}, 64'd0);
    chk("midrst_lo", {32'd0, bus.LO}, 64'd0);
    chk("midrst_done", {63'd0, bus.Done}, 64'd0);
    $display("reset mid-run busy=%0d hi=%h lo=%h", bus.Busy, bus.HI, bus.LO);
    cur_hi = '0;
    cur_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'd2, 32'd9, 32'd3, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
